// File: rtl/slot_pkg.sv
// Shared constants for the slot machine sequencer: FSM encoding, engine mode
// codes and the engine result width.
package slot_pkg;

    localparam int RES_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SPIN   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_SAMPLE = 2'd3;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE1     = 2'd1;
    localparam logic [1:0] MODE2     = 2'd2;
    localparam logic [1:0] MODE3     = 2'd3;

    // Engine start vector for a mode code; MODE_NONE gives no start at all.
    function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
        logic [2:0] vec;
        case (mode)
            MODE1:   vec = 3'b001;
            MODE2:   vec = 3'b010;
            MODE3:   vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Front-panel and engine-side signal bundle of the slot game sequencer.
interface slot_game_ctrl_if #(
    parameter int CREDIT_W = 8
);
    import slot_pkg::*;

    logic                coin;
    logic                play;
    logic [1:0]          mode_sel;
    logic [RES_W-1:0]    eng_out1;
    logic [RES_W-1:0]    eng_out2;
    logic [RES_W-1:0]    eng_out3;
    logic [2:0]          eng_won;
    logic [2:0]          start;
    logic [CREDIT_W-1:0] credits;
    logic [RES_W-1:0]    last_out;
    logic                last_won;
    logic                busy;
    logic                done;

    modport slave (
        input  coin, play, mode_sel, eng_out1, eng_out2, eng_out3, eng_won,
        output start, credits, last_out, last_won, busy, done
    );

    modport master (
        output coin, play, mode_sel, eng_out1, eng_out2, eng_out3, eng_won,
        input  start, credits, last_out, last_won, busy, done
    );

endinterface

// File: rtl/slot_credit_ctr.sv
// Saturating credit balance: +1 per coin, -BET per accepted play, +PAYOUT per
// win, any of them in the same cycle; never wraps.
module slot_credit_ctr #(
    parameter int CREDIT_W = 8,
    parameter int BET      = 1,
    parameter int PAYOUT   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc1_i,
    input  logic                dec_bet_i,
    input  logic                add_payout_i,
    output logic [CREDIT_W-1:0] credits_o
);

    localparam logic [CREDIT_W:0] BET_W    = (CREDIT_W+1)'(BET);
    localparam logic [CREDIT_W:0] PAYOUT_W = (CREDIT_W+1)'(PAYOUT);
    localparam logic [CREDIT_W:0] ZERO_W   = {(CREDIT_W+1){1'b0}};

    logic [CREDIT_W-1:0] credits_q;
    logic [CREDIT_W-1:0] credits_d;
    logic [CREDIT_W:0]   sum_s;

    // Bets are only taken when the balance covers them, so the extra top bit
    // can only mean overflow and selects the saturated value.
    always_comb begin
        sum_s = {1'b0, credits_q}
              + {{CREDIT_W{1'b0}}, inc1_i}
              + (add_payout_i ? PAYOUT_W : ZERO_W)
              - (dec_bet_i    ? BET_W    : ZERO_W);
        credits_d = sum_s[CREDIT_W] ? {CREDIT_W{1'b1}} : sum_s[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= {CREDIT_W{1'b0}};
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o = credits_q;

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine sequencer: takes a bet, spins one engine for a fixed window,
// lets it settle, latches its result and pays out on a win.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int SPIN_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CREDIT_W      = 8,
    parameter int BET           = 1,
    parameter int PAYOUT        = 5
) (
    input  logic             clk,
    input  logic             rst,
    slot_game_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SPIN_LOAD   = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]          state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [1:0]          mode_q,     mode_d;
    logic [RES_W-1:0]    last_out_q, last_out_d;
    logic                last_won_q, last_won_d;
    logic [2:0]          start_q;
    logic                busy_q;
    logic                done_q;

    logic                accept_s;
    logic                dec_bet_s;
    logic                add_payout_s;
    logic [RES_W-1:0]    sel_out_s;
    logic                sel_won_s;
    logic [CREDIT_W-1:0] credits_s;

    // Result mux keyed on the latched mode, so mode_sel may move mid-game.
    always_comb begin
        case (mode_q)
            MODE1: begin
                sel_out_s = bus.eng_out1;
                sel_won_s = bus.eng_won[0];
            end
            MODE2: begin
                sel_out_s = bus.eng_out2;
                sel_won_s = bus.eng_won[1];
            end
            MODE3: begin
                sel_out_s = bus.eng_out3;
                sel_won_s = bus.eng_won[2];
            end
            default: begin
                sel_out_s = {RES_W{1'b0}};
                sel_won_s = 1'b0;
            end
        endcase
    end

    assign accept_s = bus.play && (bus.mode_sel != MODE_NONE)
                      && (credits_s >= CREDIT_W'(BET));

    // Game sequencing: IDLE -> SPIN -> SETTLE -> SAMPLE -> IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        last_out_d   = last_out_q;
        last_won_d   = last_won_q;
        dec_bet_s    = 1'b0;
        add_payout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SPIN;
                    mode_d    = bus.mode_sel;
                    cnt_d     = SPIN_LOAD;
                    dec_bet_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SPIN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                last_out_d   = sel_out_s;
                last_won_d   = sel_won_s;
                add_payout_s = sel_won_s;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            mode_q     <= MODE_NONE;
            last_out_q <= {RES_W{1'b0}};
            last_won_q <= 1'b0;
            start_q    <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            last_out_q <= last_out_d;
            last_won_q <= last_won_d;
            start_q    <= (state_d == ST_SPIN) ? mode_onehot(mode_d) : 3'b000;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_SAMPLE);
        end
    end

    slot_credit_ctr #(
        .CREDIT_W (CREDIT_W),
        .BET      (BET),
        .PAYOUT   (PAYOUT)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .inc1_i       (bus.coin),
        .dec_bet_i    (dec_bet_s),
        .add_payout_i (add_payout_s),
        .credits_o    (credits_s)
    );

    assign bus.start    = start_q;
    assign bus.credits  = credits_s;
    assign bus.last_out = last_out_q;
    assign bus.last_won = last_won_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Self-checking bench for slot_game_ctrl: directed scenarios then random
// traffic, all compared every cycle against a game-timeline model.
module tb_slot_game_ctrl;

    localparam int SPIN   = 16;
    localparam int SETTLE = 4;
    localparam int CW     = 8;
    localparam int BET    = 1;
    localparam int PAYOUT = 5;
    localparam int GAME   = SPIN + SETTLE + 1;
    localparam int CMAX   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slot_game_ctrl_if #(.CREDIT_W(CW)) bus();

    slot_game_ctrl #(
        .SPIN_CYCLES   (SPIN),
        .SETTLE_CYCLES (SETTLE),
        .CREDIT_W      (CW),
        .BET           (BET),
        .PAYOUT        (PAYOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_age counts cycles since the accepted play edge (0 = no game).
    int m_cred, m_age, m_mode, m_lout, m_lwon;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cred = 0; m_age = 0; m_mode = 0; m_lout = 0; m_lwon = 0;
    endtask

    function automatic int pick_out(input int m);
        case (m)
            1:       return int'(bus.eng_out1);
            2:       return int'(bus.eng_out2);
            3:       return int'(bus.eng_out3);
            default: return 0;
        endcase
    endfunction

    task automatic model_update();
        int nc;
        if (rst) begin
            m_reset();
        end else begin
            nc = m_cred + int'(bus.coin);
            if (m_age == GAME) begin
                m_lout = pick_out(m_mode);
                m_lwon = int'(bus.eng_won[m_mode-1]);
                if (m_lwon != 0) nc += PAYOUT;
                m_age = 0;
            end else if (m_age > 0) begin
                m_age++;
            end else if (bus.play && bus.mode_sel != 2'd0 && m_cred >= BET) begin
                m_age  = 1;
                m_mode = int'(bus.mode_sel);
                nc    -= BET;
            end
            m_cred = (nc > CMAX) ? CMAX : nc;
        end
    endtask

    task automatic compare_all();
        logic [2:0] es;
        es = (m_age >= 1 && m_age <= SPIN) ? 3'(1 << (m_mode - 1)) : 3'b000;
        check_eq("credits",  32'(bus.credits),  m_cred);
        check_eq("start",    32'(bus.start),    32'(es));
        check_eq("busy",     32'(bus.busy),     32'(m_age != 0));
        check_eq("done",     32'(bus.done),     32'(m_age == GAME));
        check_eq("last_out", 32'(bus.last_out), m_lout);
        check_eq("last_won", 32'(bus.last_won), m_lwon);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit c, input bit p, input logic [1:0] ms);
        bus.coin     = c;
        bus.play     = p;
        bus.mode_sel = ms;
    endtask

    task automatic finish_game();
        for (int i = 0; i < 4 * GAME && m_age != 0; i++) tick();
        check_eq("game_ends", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 2'd0);
        bus.eng_out1 = 10'd100;
        bus.eng_out2 = 10'd200;
        bus.eng_out3 = 10'd517;
        bus.eng_won  = 3'b000;
        m_reset();
        tick();
        tick();
        rst = 1'b0;

        // Three coins.
        repeat (3) begin set_in(1'b1, 1'b0, 2'd0); tick(); end
        set_in(1'b0, 1'b0, 2'd0);
        tick();
        check_eq("coins3_credits", 32'(bus.credits), 32'd3);

        // Winning game on mode 3.
        bus.eng_won = 3'b100;
        set_in(1'b0, 1'b1, 2'd3);
        tick();
        set_in(1'b0, 1'b0, 2'd0);
        check_eq("bet_taken", 32'(bus.credits), 32'd2);
        check_eq("start_m3", 32'(bus.start), 32'd4);
        repeat (GAME - 1) tick();
        check_eq("done_at_21", 32'(bus.done), 32'd1);
        tick();
        check_eq("win_last_out", 32'(bus.last_out), 32'd517);
        check_eq("win_last_won", 32'(bus.last_won), 32'd1);
        check_eq("win_credits",  32'(bus.credits),  32'd7);

        // Plays refused for no credit and for mode 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b1, 2'd1);
        tick();
        set_in(1'b0, 1'b0, 2'd0);
        check_eq("nocred_busy", 32'(bus.busy), 32'd0);
        repeat (5) begin set_in(1'b1, 1'b0, 2'd0); tick(); end
        set_in(1'b0, 1'b1, 2'd0);
        tick();
        set_in(1'b0, 1'b0, 2'd0);
        check_eq("mode0_credits", 32'(bus.credits), 32'd5);
        check_eq("mode0_busy",    32'(bus.busy),    32'd0);

        // Mode 1 game with mode_sel churn, a stray play and a coin mid-spin.
        bus.eng_won  = 3'b110;
        bus.eng_out1 = 10'd33;
        bus.eng_out2 = 10'd44;
        set_in(1'b0, 1'b1, 2'd1);
        tick();
        set_in(1'b0, 1'b0, 2'd2);
        repeat (3) tick();
        set_in(1'b0, 1'b1, 2'd2);
        tick();
        set_in(1'b1, 1'b0, 2'd2);
        tick();
        set_in(1'b0, 1'b0, 2'd2);
        check_eq("spin_coin", 32'(bus.credits), 32'd5);
        check_eq("spin_start_m1", 32'(bus.start), 32'd1);
        finish_game();
        check_eq("m1_last_out", 32'(bus.last_out), 32'd33);
        check_eq("m1_last_won", 32'(bus.last_won), 32'd0);

        // Saturation: win coinciding with a coin near the top.
        set_in(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 300 && m_cred < 254; i++) tick();
        bus.eng_won = 3'b010;
        set_in(1'b0, 1'b1, 2'd2);
        tick();
        set_in(1'b0, 1'b0, 2'd0);
        check_eq("sat_bet", 32'(bus.credits), 32'd253);
        for (int i = 0; i < 4 * GAME && m_age != 0; i++) begin
            bus.coin = (m_age == GAME);
            tick();
        end
        bus.coin = 1'b0;
        check_eq("sat_credits", 32'(bus.credits), 32'd255);

        // Asynchronous reset in the middle of a mode 2 spin.
        set_in(1'b0, 1'b1, 2'd2);
        tick();
        set_in(1'b0, 1'b0, 2'd0);
        repeat (4) tick();
        check_eq("pre_rst_start", 32'(bus.start), 32'd2);
        #3 rst = 1'b1;
        #1;
        check_eq("rst_start",   32'(bus.start),   32'd0);
        check_eq("rst_credits", 32'(bus.credits), 32'd0);
        check_eq("rst_busy",    32'(bus.busy),    32'd0);
        m_reset();
        tick();
        tick();
        rst = 1'b0;
        repeat (30) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   2'($urandom_range(0, 3)));
            bus.eng_out1 = 10'($urandom);
            bus.eng_out2 = 10'($urandom);
            bus.eng_out3 = 10'($urandom);
            bus.eng_won  = 3'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
